// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, {pc,inst} queue to decode
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2  // power of 2, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  // Pointer width indexes QDEPTH entries; counter width holds 0..QDEPTH inclusive.
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] tag_wptr_q, tag_wptr_d;
  logic [PW-1:0] tag_rptr_q, tag_rptr_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] q_wptr_q, q_wptr_d;
  logic [PW-1:0] q_rptr_q, q_rptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage arrays carry no reset: validity is tracked solely by the counters and pointers.
  logic [31:0] tag_mem    [QDEPTH];
  logic [31:0] q_pc_mem   [QDEPTH];
  logic [31:0] q_inst_mem [QDEPTH];

  logic [CW:0] credit_sum;
  logic        req_hs;
  logic        rsp_keep;
  logic        q_empty;
  logic        id_pop;
  logic [31:0] tag_head;

  // Credit check, handshakes and decode-facing outputs.
  always_comb begin
    credit_sum     = {1'b0, out_q} + {1'b0, count_q};
    // Every issued request owns a queue slot, so the queue can never overflow.
    imem_req_valid = rst_n & (credit_sum < QDEPTH_W);
    imem_req_addr  = pc_q;
    req_hs         = imem_req_valid & imem_req_ready;
    tag_head       = tag_mem[tag_rptr_q];
    // A response is stale if it was in flight at some redirect, or arrives with one.
    rsp_keep       = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
    q_empty        = (count_q == '0);
    id_valid       = ~q_empty & ~redirect_valid;
    id_pop         = id_valid & id_ready;
    id_inst        = q_empty ? 32'd0 : q_inst_mem[q_rptr_q];
    id_pc          = q_empty ? 32'd0 : q_pc_mem[q_rptr_q];
  end

  // Next-state for PC, tag FIFO, outstanding/drop counters and data queue.
  always_comb begin
    pc_d       = pc_q;
    tag_wptr_d = tag_wptr_q;
    tag_rptr_d = tag_rptr_q;
    drop_d     = drop_q;
    q_wptr_d   = q_wptr_q;
    q_rptr_d   = q_rptr_q;
    count_d    = count_q;

    if (req_hs) begin
      tag_wptr_d = tag_wptr_q + PW'(1);
      pc_d       = pc_q + 32'd4;
    end
    if (imem_rsp_valid) begin
      tag_rptr_d = tag_rptr_q + PW'(1);
    end
    out_d = out_q + CW'(req_hs) - CW'(imem_rsp_valid);

    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the abandoned path.
      pc_d     = {redirect_pc[31:2], 2'b00};
      drop_d   = out_d;
      q_wptr_d = '0;
      q_rptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_keep) begin
        q_wptr_d = q_wptr_q + PW'(1);
      end
      if (id_pop) begin
        q_rptr_d = q_rptr_q + PW'(1);
      end
      count_d = count_q + CW'(rsp_keep) - CW'(id_pop);
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      q_wptr_q   <= '0;
      q_rptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_wptr_q <= tag_wptr_d;
      tag_rptr_q <= tag_rptr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      q_wptr_q   <= q_wptr_d;
      q_rptr_q   <= q_rptr_d;
      count_q    <= count_d;
    end
  end

  // Record issued addresses and buffer kept responses paired with their address tag.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      tag_mem[tag_wptr_q] <= pc_q;
    end
    if (rsp_keep) begin
      q_pc_mem[q_wptr_q]   <= tag_head;
      q_inst_mem[q_wptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: requests in flight (with stale flag), buffered instructions, next fetch PC.
  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  pend_t       pend[$];
  ent_t        buff[$];
  logic [31:0] exp_pc;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc, input bit mrdy, input bit mrsp);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = mrdy;
    imem_rsp_valid = mrsp && (pend.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? memw(pend[0].addr) : $urandom;
  endtask

  task automatic model_check();
    bit e_rv;
    e_rv = (pend.size() + buff.size()) < QDEPTH;
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr", imem_req_addr, exp_pc);
    chk("id_valid", 32'(id_valid), 32'(buff.size() > 0 && !redirect_valid));
    if (buff.size() > 0) begin
      chk("id_pc", id_pc, buff[0].pc);
      chk("id_inst", id_inst, buff[0].inst);
    end
  endtask

  task automatic model_update();
    bit    e_rv, hs, pop;
    pend_t p;
    e_rv = (pend.size() + buff.size()) < QDEPTH;
    hs   = e_rv && imem_req_ready;
    pop  = (buff.size() > 0) && !redirect_valid && id_ready;
    if (pop) void'(buff.pop_front());
    if (imem_rsp_valid) begin
      p = pend.pop_front();
      if (!p.stale && !redirect_valid) buff.push_back('{pc: p.addr, inst: memw(p.addr)});
    end
    if (hs) begin
      pend.push_back('{addr: exp_pc, stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      buff.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic finish_cycle();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc, input bit mrdy, input bit mrsp);
    drive(rdy, rv, rpc, mrdy, mrsp);
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle_inputs();
    id_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    pend.delete(); buff.delete(); exp_pc = RESET_PC;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    chk("rst req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst id_valid", 32'(id_valid), 32'd0);
    chk("rst req_addr", imem_req_addr, RESET_PC);
    chk("rst id_inst", id_inst, 32'd0);
    chk("rst id_pc", id_pc, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Directed vectors from reset: mem always ready with 1-cycle responses.
  typedef struct {
    bit rdy; bit redir; logic [31:0] rpc;
    bit e_rv; logic [31:0] e_addr; bit e_idv; logic [31:0] e_pc;
  } vec_t;
  vec_t vecs[17];

  task automatic wait_first_id(input string name, input logic [31:0] want);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      drive(1, 0, 0, 1, 1);
      @(negedge clk);
      if (id_valid) begin
        seen = 1;
        chk({name, " first id_pc"}, id_pc, want);
        chk({name, " first id_inst"}, id_inst, memw(want));
      end
      finish_cycle();
    end
    chk({name, " id_valid seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0,          1, 32'h0,   0, 0};
    vecs[1]  = '{1, 0, 0,          1, 32'h4,   0, 0};
    vecs[2]  = '{1, 0, 0,          0, 32'h8,   1, 32'h0};
    vecs[3]  = '{1, 0, 0,          1, 32'h8,   1, 32'h4};
    vecs[4]  = '{1, 0, 0,          1, 32'hC,   0, 0};
    vecs[5]  = '{1, 0, 0,          0, 32'h10,  1, 32'h8};
    vecs[6]  = '{0, 0, 0,          1, 32'h10,  1, 32'hC};
    vecs[7]  = '{0, 0, 0,          0, 32'h14,  1, 32'hC};
    vecs[8]  = '{0, 0, 0,          0, 32'h14,  1, 32'hC};
    vecs[9]  = '{1, 0, 0,          0, 32'h14,  1, 32'hC};
    vecs[10] = '{0, 0, 0,          1, 32'h14,  1, 32'h10};
    vecs[11] = '{0, 0, 0,          0, 32'h18,  1, 32'h10};
    vecs[12] = '{0, 0, 0,          0, 32'h18,  1, 32'h10};
    vecs[13] = '{1, 1, 32'h103,    0, 32'h18,  0, 0};
    vecs[14] = '{1, 0, 0,          1, 32'h100, 0, 0};
    vecs[15] = '{1, 0, 0,          1, 32'h104, 0, 0};
    vecs[16] = '{1, 0, 0,          0, 32'h108, 1, 32'h100};

    // Tests 1, 2 and redirect alignment: table-driven.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rdy, vecs[i].redir, vecs[i].rpc, 1, 1);
      @(negedge clk);
      chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_idv));
      if (vecs[i].e_idv) begin
        chk($sformatf("vec%0d id_pc", i), id_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d id_inst", i), id_inst, memw(vecs[i].e_pc));
      end
      finish_cycle();
    end

    // Test 3: two fetches in flight at 0x10/0x14, redirect to 0x100 drops both.
    do_reset();
    cycle(1, 1, 32'h10, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    drive(1, 1, 32'h100, 1, 0);
    @(negedge clk);
    chk("t3 req_valid full credit", 32'(imem_req_valid), 32'd0);
    finish_cycle();
    wait_first_id("t3", 32'h100);

    // Test 4: redirect with simultaneous request handshake (0x20) and response arrival.
    do_reset();
    cycle(1, 1, 32'h1C, 0, 0);
    cycle(1, 0, 0, 1, 0);
    drive(1, 1, 32'h200, 1, 1);
    @(negedge clk);
    chk("t4 req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4 req_addr", imem_req_addr, 32'h20);
    finish_cycle();
    drive(1, 0, 0, 1, 1);
    @(negedge clk);
    chk("t4 next req_addr", imem_req_addr, 32'h200);
    chk("t4 id_valid low", 32'(id_valid), 32'd0);
    finish_cycle();
    wait_first_id("t4", 32'h200);

    // Test 5: PC wrap from 0xFFFF_FFFC to 0.
    do_reset();
    cycle(1, 1, 32'hFFFF_FFFE, 0, 0);
    drive(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("t5 addr top", imem_req_addr, 32'hFFFF_FFFC);
    finish_cycle();
    drive(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("t5 addr wrap", imem_req_addr, 32'h0);
    finish_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    // Test 6: asynchronous reset with a full queue.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t6 id_valid before reset", 32'(id_valid), 32'd1);
    finish_cycle();
    rst_n = 1'b0;
    #1;
    chk("t6 id_valid in reset", 32'(id_valid), 32'd0);
    chk("t6 req_valid in reset", 32'(imem_req_valid), 32'd0);
    chk("t6 id_pc in reset", id_pc, 32'd0);
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("t6 first req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6 first addr", imem_req_addr, RESET_PC);
    finish_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
